sink_mc: RTL and testbench



---
 rtl/sink_pkg.sv | 12 +
 rtl/sink_lane.sv | 52 +++++
 rtl/sink_mc.sv | 50 +++++
 tb/tb_sink_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sink_pkg.sv
// sink_pkg: LFSR taps plus per-lane seed and Galois step helpers shared by sink_mc and sink_lane
package sink_pkg;
   localparam logic [15:0] SINK_LFSR_TAPS = 16'hB400;
   function automatic logic [15:0] lane_seed(input logic [15:0] base, input int lane);
      logic [15:0] s;
      s = base ^ 16'(lane + 1);
      return (s == 16'h0) ? 16'h0001 : s;
   endfunction
   function automatic logic [15:0] lfsr_next(input logic [15:0] state);
      return (state >> 1) ^ (state[0] ? SINK_LFSR_TAPS : 16'h0);
   endfunction
endpackage

// File: rtl/sink_lane.sv
// sink_lane: one val/rdy lane checking messages against its harness-loaded expected memory
// Define SINK_VERBOSE_EN to trace every handshake with its result
module sink_lane
   import sink_pkg::*;
#(
   parameter int          p_width     = 16,
   parameter int          p_nmsgs     = 4,
   parameter int          p_max_delay = 0,
   parameter logic [15:0] p_seed      = 16'hACE1,
   parameter int          p_lane      = 0,
   parameter int          p_idx_width = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               val,
   output logic               rdy,
   input  logic [p_width-1:0] msg,
   output logic               lane_done,
   output logic               mismatch_pulse
);
   localparam int iw = (p_idx_width < 1) ? 1 : p_idx_width;
   localparam int dw = (p_max_delay < 1) ? 1 : $clog2(p_max_delay + 1);
   localparam logic [15:0] modulus = 16'(p_max_delay + 1);
   // depth rounded to a power of two so idx indexes it at full width
   logic [p_width-1:0] mem [1 << iw];
   logic [iw-1:0] idx;
   logic [dw-1:0] delay;
   logic [15:0] lfsr, lfsr_nx;
   logic hs;
   assign lane_done = idx == iw'(p_nmsgs);
   assign rdy = !lane_done && delay == '0;
   assign hs = val && rdy;
   assign mismatch_pulse = hs && (msg !== mem[idx]);
   assign lfsr_nx = lfsr_next(lfsr);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         idx <= '0;
         delay <= '0;
         lfsr <= lane_seed(p_seed, p_lane);
      end else if (hs) begin
         idx <= idx + 1'b1;
         delay <= dw'(lfsr_nx % modulus);
         lfsr <= lfsr_nx;
      end else if (delay != '0)
         delay <= delay - 1'b1;
`ifdef SINK_VERBOSE_EN
   always_ff @(posedge clk)
      if (!reset && hs)
         $display("%0t sink lane %0d idx %0d got %h exp %h %s", $time, p_lane, idx, msg, mem[idx],
                  mismatch_pulse ? "failed" : "passed");
`endif
endmodule

// File: rtl/sink_mc.sv
// sink_mc: multi-lane test sink with random backpressure, global mismatch count and done flag
// Handshake tracing is available via SINK_VERBOSE_EN (compiled into sink_lane)
module sink_mc
   import sink_pkg::*;
#(
   parameter int          p_width      = 16,
   parameter int          p_nmsgs      = 4,
   parameter int          p_nchan      = 2,
   parameter int          p_max_delay  = 0,
   parameter logic [15:0] p_seed       = 16'hACE1,
   parameter int          p_idx_width  = $clog2(p_nmsgs + 1),
   parameter int          p_fail_width = $clog2(p_nchan * p_nmsgs + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [p_nchan-1:0]         val,
   output logic [p_nchan-1:0]         rdy,
   input  logic [p_nchan*p_width-1:0] msg,
   output logic                       done,
   output logic [p_nchan-1:0]         lane_done,
   output logic [p_fail_width-1:0]    num_failed,
   output logic                       fail
);
   logic [p_nchan-1:0] mm;
   logic [p_fail_width-1:0] mm_cnt;
   for (genvar i = 0; i < p_nchan; i++) begin : g_lane
      sink_lane #(
         .p_width(p_width), .p_nmsgs(p_nmsgs), .p_max_delay(p_max_delay),
         .p_seed(p_seed), .p_lane(i), .p_idx_width(p_idx_width)
      ) u_lane (
         .clk(clk), .reset(reset), .val(val[i]), .rdy(rdy[i]),
         .msg(msg[i*p_width +: p_width]), .lane_done(lane_done[i]), .mismatch_pulse(mm[i])
      );
   end
   // simultaneous mismatches on several lanes all count in the same cycle
   always_comb begin
      mm_cnt = '0;
      for (int j = 0; j < p_nchan; j++)
         mm_cnt = mm_cnt + p_fail_width'(mm[j]);
   end
   assign done = &lane_done;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         num_failed <= '0;
         fail <= 1'b0;
      end else begin
         num_failed <= num_failed + mm_cnt;
         fail <= fail | (|mm);
      end
endmodule

// File: tb/tb_sink_mc.sv
// tb_sink_mc: randomized self-checking bench for sink_mc against a list/arithmetic reference model
module tb_sink_mc;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   logic [1:0] val0 = '0, rdy0, ld0;
   logic [31:0] msg0 = '0;
   logic done0, fail0;
   logic [3:0] nf0;
   logic [1:0] val1 = '0, rdy1, ld1;
   logic [31:0] msg1 = '0;
   logic done1, fail1;
   logic [4:0] nf1;

   int n_tests = 0, n_fail = 0;
   logic [15:0] e0 [2][4];
   logic [15:0] e1 [2][8];

   sink_mc #(.p_width(16), .p_nmsgs(4), .p_nchan(2), .p_max_delay(0), .p_seed(16'hACE1)) d0 (
      .clk(clk), .reset(reset), .val(val0), .rdy(rdy0), .msg(msg0),
      .done(done0), .lane_done(ld0), .num_failed(nf0), .fail(fail0));
   sink_mc #(.p_width(16), .p_nmsgs(8), .p_nchan(2), .p_max_delay(3), .p_seed(16'hACE1)) d1 (
      .clk(clk), .reset(reset), .val(val1), .rdy(rdy1), .msg(msg1),
      .done(done1), .lane_done(ld1), .num_failed(nf1), .fail(fail1));

   function automatic logic [15:0] ref_step(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic load0;
      for (int k = 0; k < 4; k++) begin
         d0.g_lane[0].u_lane.mem[k] = e0[0][k];
         d0.g_lane[1].u_lane.mem[k] = e0[1][k];
      end
   endtask

   task automatic load1;
      for (int k = 0; k < 8; k++) begin
         d1.g_lane[0].u_lane.mem[k] = e1[0][k];
         d1.g_lane[1].u_lane.mem[k] = e1[1][k];
      end
   endtask

   task automatic rand_e0;
      for (int l = 0; l < 2; l++)
         for (int k = 0; k < 4; k++) e0[l][k] = 16'($urandom);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      val0 = '0;
      val1 = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // drives 4 back-to-back messages per lane on d0 and checks status every cycle
   task automatic stream0(input logic [15:0] m [2][4], input string nm);
      int nf = 0;
      for (int k = 0; k <= 4; k++) begin
         n_tests++;
         if (rdy0 !== (k < 4 ? 2'b11 : 2'b00)) begin
            n_fail++; $display("FAIL %s rdy k=%0d got %b want %b", nm, k, rdy0, (k < 4 ? 2'b11 : 2'b00));
         end
         n_tests++;
         if (nf0 !== 4'(nf)) begin
            n_fail++; $display("FAIL %s num_failed k=%0d got %0d want %0d", nm, k, nf0, nf);
         end
         n_tests++;
         if (fail0 !== (nf != 0)) begin
            n_fail++; $display("FAIL %s fail k=%0d got %b want %b", nm, k, fail0, nf != 0);
         end
         n_tests++;
         if (done0 !== (k == 4)) begin
            n_fail++; $display("FAIL %s done k=%0d got %b want %b", nm, k, done0, k == 4);
         end
         if (k < 4) begin
            val0 = 2'b11;
            msg0 = {m[1][k], m[0][k]};
            for (int l = 0; l < 2; l++) if (m[l][k] !== e0[l][k]) nf++;
            @(negedge clk);
         end
      end
      val0 = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({rdy0, ld0, done0, nf0, fail0} !== {2'b11, 2'b00, 1'b0, 4'd0, 1'b0}) begin
         n_fail++; $display("FAIL reset_d0 got %b want %b", {rdy0, ld0, done0, nf0, fail0}, 10'b1100000000);
      end
      n_tests++;
      if ({rdy1, ld1, done1, nf1, fail1} !== {2'b11, 2'b00, 1'b0, 5'd0, 1'b0}) begin
         n_fail++; $display("FAIL reset_d1 got %b want %b", {rdy1, ld1, done1, nf1, fail1}, 11'b11000000000);
      end
      reset = 1'b0;
   endtask

   task automatic test_stream_pass;
      rand_e0();
      e0[0][0] = 16'd5; e0[0][1] = 16'd2; e0[0][2] = 16'd18; e0[0][3] = 16'd3;
      load0();
      do_reset();
      stream0(e0, "pass");
   endtask

   task automatic test_mismatch;
      logic [15:0] m [2][4];
      m = e0;
      m[0][1] = 16'd7;
      do_reset();
      stream0(m, "mismatch");
   endtask

   task automatic test_dual_mismatch;
      logic [15:0] m [2][4];
      rand_e0();
      load0();
      m = e0;
      m[0][2] = ~e0[0][2];
      m[1][2] = e0[1][2] ^ 16'h0100;
      do_reset();
      stream0(m, "dual");
   endtask

   task automatic test_x_and_after_done;
      logic [15:0] m [2][4];
      m = e0;
      m[0][0] = 'x;
      do_reset();
      stream0(m, "xmsg");
      for (int c = 0; c < 3; c++) begin
         val0 = 2'($urandom_range(1, 3));
         msg0 = $urandom;
         @(negedge clk);
         n_tests++;
         if ({rdy0, done0, nf0, fail0} !== {2'b00, 1'b1, 4'd1, 1'b1}) begin
            n_fail++; $display("FAIL after_done c=%0d got %b want %b", c, {rdy0, done0, nf0, fail0}, 8'b00100011);
         end
      end
      val0 = '0;
   endtask

   task automatic test_async_reset;
      do_reset();
      val0 = 2'b01;
      msg0 = {16'h0, ~e0[0][0]};
      @(negedge clk);
      msg0 = {16'h0, e0[0][1]};
      @(negedge clk);
      val0 = '0;
      n_tests++;
      if (nf0 !== 4'd1) begin
         n_fail++; $display("FAIL async_pre num_failed got %0d want 1", nf0);
      end
      #2 reset = 1'b1;
      #1;
      n_tests++;
      if ({rdy0, ld0, nf0, fail0} !== {2'b11, 2'b00, 4'd0, 1'b0}) begin
         n_fail++; $display("FAIL async_reset got %b want %b", {rdy0, ld0, nf0, fail0}, 9'b110000000);
      end
      #1 reset = 1'b0;
      @(negedge clk);
      stream0(e0, "replay");
   endtask

   task automatic test_backpressure;
      logic [15:0] s;
      int gap [2][8];
      int cnt [2], ready_at [2];
      int nf = 0, c = 0;
      for (int l = 0; l < 2; l++) begin
         s = 16'hACE1 ^ 16'(l + 1);
         if (s == 0) s = 16'h0001;
         for (int k = 0; k < 8; k++) begin
            s = ref_step(s);
            gap[l][k] = int'(s % 16'd4);
            e1[l][k] = 16'($urandom);
         end
         cnt[l] = 0;
         ready_at[l] = 0;
      end
      load1();
      do_reset();
      while ((cnt[0] < 8 || cnt[1] < 8) && c < 400) begin
         for (int l = 0; l < 2; l++) begin
            logic er, v, bad;
            er = cnt[l] < 8 && c >= ready_at[l];
            n_tests++;
            if (rdy1[l] !== er) begin
               n_fail++; $display("FAIL bp_rdy lane=%0d cyc=%0d got %b want %b", l, c, rdy1[l], er);
            end
            v = ($urandom_range(0, 3) != 0);
            bad = ($urandom_range(0, 7) == 0);
            val1[l] = v;
            msg1[l*16 +: 16] = (cnt[l] < 8) ? (bad ? ~e1[l][cnt[l]] : e1[l][cnt[l]]) : 16'($urandom);
            if (er && v) begin
               if (bad) nf++;
               ready_at[l] = c + 1 + gap[l][cnt[l]];
               cnt[l]++;
            end
         end
         @(negedge clk);
         c++;
      end
      val1 = '0;
      n_tests++;
      if (c >= 400) begin
         n_fail++; $display("FAIL bp_timeout cyc=%0d got cnt %0d/%0d want 8/8", c, cnt[0], cnt[1]);
      end
      n_tests++;
      if ({done1, ld1, nf1, fail1} !== {1'b1, 2'b11, 5'(nf), nf != 0}) begin
         n_fail++; $display("FAIL bp_final got done=%b nf=%0d fail=%b want done=1 nf=%0d fail=%b",
                            done1, nf1, fail1, nf, nf != 0);
      end
   endtask

   initial begin
      test_reset();
      test_stream_pass();
      test_mismatch();
      test_dual_mismatch();
      test_x_and_after_done();
      test_async_reset();
      repeat (3) test_backpressure();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
